// File: rtl/imem_loader.sv
// Instruction memory loader: accepts a framed program over a byte stream, writes it from
// address 0 and releases the CPU once the payload XOR checksum matches.
`timescale 1ns/1ps
module imem_loader #(
  parameter int                ADDR_W = 8,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] MAGIC  = 8'hA5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  input  logic [ADDR_W-1:0] i_fetch_pc,
  output logic [DATA_W-1:0] o_fetch_instr,
  output logic              o_cpu_hold,
  output logic              o_load_done,
  output logic              o_load_err,
  output logic [ADDR_W:0]   o_byte_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LEN = DEPTH[ADDR_W:0];

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_xor;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_byte_count;
  logic              r_load_done;
  logic              r_load_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_xfer;
  logic              w_is_magic;
  logic [ADDR_W:0]   w_cnt_next;
  logic [ADDR_W-1:0] w_len_byte;

  assign o_in_ready   = (r_state != S_RUN);
  assign w_xfer       = i_in_valid && o_in_ready;
  assign w_is_magic   = (i_in_data == MAGIC);
  assign w_cnt_next   = r_byte_count + (ADDR_W+1)'(1);
  assign w_len_byte   = i_in_data[ADDR_W-1:0];

  assign o_cpu_hold    = !r_load_done;
  assign o_load_done   = r_load_done;
  assign o_load_err    = r_load_err;
  assign o_byte_count  = r_byte_count;
  assign o_fetch_instr = (r_state == S_RUN) ? r_mem[i_fetch_pc] : '0;

  // Memory contents survive reset; they are only exposed once a frame passes in RUN.
  always_ff @(posedge i_clk) begin
    if (w_xfer && (r_state == S_DATA))
      r_mem[r_wr_addr] <= i_in_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
      r_byte_count <= '0;
    end else if (w_xfer) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_magic) r_state <= S_LEN;
        end
        S_LEN: begin
          // A length byte of zero stands for a full-memory frame.
          r_len        <= (w_len_byte == '0) ? FULL_LEN : {1'b0, w_len_byte};
          r_wr_addr    <= '0;
          r_xor        <= '0;
          r_byte_count <= '0;
          r_state      <= S_DATA;
        end
        S_DATA: begin
          r_wr_addr    <= r_wr_addr + ADDR_W'(1);
          r_xor        <= r_xor ^ i_in_data;
          r_byte_count <= w_cnt_next;
          if (w_cnt_next == r_len) r_state <= S_CSUM;
        end
        S_CSUM: begin
          if (i_in_data == r_xor) begin
            r_state     <= S_RUN;
            r_load_done <= 1'b1;
          end else begin
            r_state    <= S_ERR;
            r_load_err <= 1'b1;
          end
        end
        S_ERR: begin
          if (w_is_magic) begin
            r_state    <= S_LEN;
            r_load_err <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames plus randomized frames checked against a
// frame-level model (payload image, checksum verdict, byte count).
`timescale 1ns/1ps
module tb_imem_loader;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_in_valid = 1'b0;
  logic [7:0] i_in_data = 8'h00;
  logic       o_in_ready;
  logic [7:0] i_fetch_pc = 8'h00;
  logic [7:0] o_fetch_instr;
  logic       o_cpu_hold;
  logic       o_load_done;
  logic       o_load_err;
  logic [8:0] o_byte_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_mem [256];
  logic       m_done;
  logic       m_err;
  int         m_count;
  logic [7:0] pl [$];

  imem_loader dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_in_valid   (i_in_valid),
    .i_in_data    (i_in_data),
    .o_in_ready   (o_in_ready),
    .i_fetch_pc   (i_fetch_pc),
    .o_fetch_instr(o_fetch_instr),
    .o_cpu_hold   (o_cpu_hold),
    .o_load_done  (o_load_done),
    .o_load_err   (o_load_err),
    .o_byte_count (o_byte_count)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge i_clk);
    i_reset = 1'b0;
    repeat (n) @(negedge i_clk);
    i_reset = 1'b1;
    m_done  = 1'b0;
    m_err   = 1'b0;
    m_count = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    i_in_valid = 1'b0;
    repeat (gap) @(negedge i_clk);
    i_in_valid = 1'b1;
    i_in_data  = b;
    k = 0;
    while (!o_in_ready && k < 50) begin
      @(negedge i_clk);
      k++;
    end
    if (!o_in_ready) chk("send_ready", {31'd0, o_in_ready}, 32'd1);
    else @(negedge i_clk);
    i_in_valid = 1'b0;
  endtask

  function automatic logic [7:0] pl_xor();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < pl.size(); i++) x ^= pl[i];
    return x;
  endfunction

  // Sends MAGIC, LEN, payload in pl, then csum; updates the model from the frame rules.
  task automatic send_frame(input logic [7:0] csum, input int gap, input bit rnd_gap);
    int g;
    g = gap;
    send_byte(8'hA5, g);
    if (rnd_gap) g = $urandom_range(0, gap);
    send_byte(8'(pl.size()), g);
    chk("count_after_len", 32'(o_byte_count), 32'd0);
    for (int i = 0; i < pl.size(); i++) begin
      if (rnd_gap) g = $urandom_range(0, gap);
      send_byte(pl[i], g);
    end
    chk("hold_before_csum", {31'd0, o_cpu_hold}, 32'd1);
    send_byte(csum, g);
    m_count = pl.size();
    for (int i = 0; i < pl.size(); i++) m_mem[i] = pl[i];
    if (csum == pl_xor()) begin
      m_done = 1'b1;
      m_err  = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    // Sampled on the negedge right after the CSUM edge: exactly one cycle of latency.
    chk("hold_after_csum", {31'd0, o_cpu_hold}, {31'd0, !m_done});
  endtask

  task automatic check_model(input string tag);
    int n;
    chk({tag, "_done"},  {31'd0, o_load_done}, {31'd0, m_done});
    chk({tag, "_err"},   {31'd0, o_load_err},  {31'd0, m_err});
    chk({tag, "_hold"},  {31'd0, o_cpu_hold},  {31'd0, !m_done});
    chk({tag, "_ready"}, {31'd0, o_in_ready},  {31'd0, !m_done});
    chk({tag, "_count"}, 32'(o_byte_count),    32'(m_count));
    if (m_done) begin
      n = (m_count < 8) ? m_count : 8;
      for (int i = 0; i < n; i++) begin
        i_fetch_pc = (m_count < 8) ? 8'(i) : 8'($urandom_range(0, m_count - 1));
        #1;
        chk({tag, "_fetch"}, {24'd0, o_fetch_instr}, {24'd0, m_mem[i_fetch_pc]});
      end
    end else begin
      i_fetch_pc = 8'($urandom);
      #1;
      chk({tag, "_nop"}, {24'd0, o_fetch_instr}, 32'd0);
    end
    @(negedge i_clk);
  endtask

  initial begin
    logic [7:0] gb;
    bit bad;
    m_done = 1'b0; m_err = 1'b0; m_count = 0;

    // 1: reset state
    do_reset(2);
    check_model("rst");
    i_fetch_pc = 8'h00; #1;
    chk("rst_fetch0", {24'd0, o_fetch_instr}, 32'd0);
    @(negedge i_clk);

    // 2: basic frame
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h00, 0, 1'b0);
    check_model("basic");
    i_in_valid = 1'b1; i_in_data = 8'hA5;
    repeat (3) @(negedge i_clk);
    i_in_valid = 1'b0;
    chk("run_stall_count", 32'(o_byte_count), 32'd3);
    chk("run_stall_done", {31'd0, o_load_done}, 32'd1);
    i_fetch_pc = 8'h02; #1;
    chk("run_stall_fetch", {24'd0, o_fetch_instr}, 32'h33);
    @(negedge i_clk);

    // 3: bad checksum then recovery through ERR
    do_reset(1);
    pl = '{8'h10, 8'h20};
    send_frame(8'h31, 0, 1'b0);
    check_model("badcs");
    pl = '{8'h7E};
    send_frame(8'h7E, 0, 1'b0);
    check_model("recover");

    // 4: garbage before a frame, 3-cycle gaps
    do_reset(1);
    send_byte(8'h00, 3);
    send_byte(8'hFF, 3);
    send_byte(8'h5A, 3);
    check_model("garbage");
    pl = '{8'h42};
    send_frame(8'h42, 3, 1'b0);
    check_model("gapped");

    // 5: full 256-byte frame, LEN=0
    do_reset(1);
    pl = {};
    for (int i = 0; i < 256; i++) pl.push_back(8'(i));
    send_frame(8'h00, 0, 1'b0);
    check_model("full");
    i_fetch_pc = 8'hFF; #1;
    chk("full_fetch_ff", {24'd0, o_fetch_instr}, 32'hFF);
    @(negedge i_clk);

    // 6: reset mid-frame, then MAGIC value as payload
    do_reset(1);
    send_byte(8'hA5, 0);
    send_byte(8'h04, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    do_reset(1);
    check_model("midrst");
    pl = '{8'hA5};
    send_frame(8'hA5, 0, 1'b0);
    check_model("magicdata");

    // 7: randomized frames, some corrupted, with optional leading garbage
    for (int t = 0; t < 8; t++) begin
      do_reset(1);
      if ($urandom_range(0, 1) == 1) begin
        gb = 8'($urandom);
        if (gb == 8'hA5) gb = 8'h00;
        send_byte(gb, $urandom_range(0, 2));
      end
      pl = {};
      for (int i = 0; i < $urandom_range(1, 24); i++) pl.push_back(8'($urandom));
      bad = ($urandom_range(0, 2) == 0);
      send_frame(bad ? (pl_xor() ^ 8'($urandom_range(1, 255))) : pl_xor(), 2, 1'b1);
      check_model("rnd");
      if (bad) begin
        pl = {};
        for (int i = 0; i < $urandom_range(1, 12); i++) pl.push_back(8'($urandom));
        send_frame(pl_xor(), 1, 1'b1);
        check_model("rnd_retry");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
